// File: rtl/iterative_divider.sv
// Radix-2 restoring divider: one trial subtract and one quotient bit per cycle, MSB first.
// Supports unsigned and two's-complement operands with a start/done handshake.
module iterative_divider #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         is_signed,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   p_q, p_d;
  logic [N-1:0]   q_q, q_d;
  logic [N-1:0]   dvsr_q, dvsr_d;
  logic [N-1:0]   raw_dvd_q, raw_dvd_d;
  logic [CW-1:0]  count_q, count_d;
  logic           q_neg_q, q_neg_d;
  logic           r_neg_q, r_neg_d;
  logic           div0_q, div0_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [N-1:0]   quotient_q, quotient_d;
  logic [N-1:0]   remainder_q, remainder_d;
  logic           div_by_zero_q, div_by_zero_d;

  logic           dvd_neg_s, dvs_neg_s;
  logic [N-1:0]   dvd_mag_s, dvs_mag_s;
  logic [N:0]     sh_p_s, trial_s;
  logic           divisor_zero_s;

  assign divisor_zero_s = (divisor == {N{1'b0}});

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = divisor_zero_s ? FINISH : RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (count_q == {CW{1'b0}}) begin
          state_d = FINISH;
        end else begin
          state_d = RUN;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // operand magnitudes and the N+1-bit trial subtract (keeps the borrow)
  always_comb begin
    dvd_neg_s = is_signed & dividend[N-1];
    dvs_neg_s = is_signed & divisor[N-1];
    dvd_mag_s = dvd_neg_s ? (-dividend) : dividend;
    dvs_mag_s = dvs_neg_s ? (-divisor) : divisor;
    sh_p_s    = {p_q, q_q[N-1]};
    trial_s   = sh_p_s - {1'b0, dvsr_q};
  end

  // datapath and registered-output next values
  always_comb begin
    p_d           = p_q;
    q_d           = q_q;
    dvsr_d        = dvsr_q;
    raw_dvd_d     = raw_dvd_q;
    count_d       = count_q;
    q_neg_d       = q_neg_q;
    r_neg_d       = r_neg_q;
    div0_d        = div0_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          p_d       = {N{1'b0}};
          q_d       = dvd_mag_s;
          dvsr_d    = dvs_mag_s;
          raw_dvd_d = dividend;
          count_d   = CW'(N - 1);
          q_neg_d   = dvd_neg_s ^ dvs_neg_s;
          r_neg_d   = dvd_neg_s;
          div0_d    = divisor_zero_s;
          busy_d    = 1'b1;
        end else begin
          busy_d    = 1'b0;
        end
      end
      RUN: begin
        if (!trial_s[N]) begin
          p_d = trial_s[N-1:0];
          q_d = {q_q[N-2:0], 1'b1};
        end else begin
          p_d = sh_p_s[N-1:0];
          q_d = {q_q[N-2:0], 1'b0};
        end
        count_d = count_q - CW'(1);
      end
      FINISH: begin
        busy_d = 1'b0;
        done_d = 1'b1;
        if (div0_q) begin
          quotient_d    = {N{1'b0}};
          remainder_d   = raw_dvd_q;
          div_by_zero_d = 1'b1;
        end else begin
          quotient_d    = q_neg_q ? (-q_q) : q_q;
          remainder_d   = r_neg_q ? (-p_q) : p_q;
          div_by_zero_d = 1'b0;
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      p_q           <= {N{1'b0}};
      q_q           <= {N{1'b0}};
      dvsr_q        <= {N{1'b0}};
      raw_dvd_q     <= {N{1'b0}};
      count_q       <= {CW{1'b0}};
      q_neg_q       <= 1'b0;
      r_neg_q       <= 1'b0;
      div0_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      quotient_q    <= {N{1'b0}};
      remainder_q   <= {N{1'b0}};
      div_by_zero_q <= 1'b0;
    end else begin
      p_q           <= p_d;
      q_q           <= q_d;
      dvsr_q        <= dvsr_d;
      raw_dvd_q     <= raw_dvd_d;
      count_q       <= count_d;
      q_neg_q       <= q_neg_d;
      r_neg_q       <= r_neg_d;
      div0_q        <= div0_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_iterative_divider.sv
// Directed-vector bench for iterative_divider (N=32) with hand-computed expectations.
module tb_iterative_divider;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [N-1:0] dividend = 32'd0;
  logic [N-1:0] divisor = 32'd0;
  logic         busy, done, div_by_zero;
  logic [N-1:0] quotient, remainder;

  int n_cmp = 0;
  int n_bad = 0;

  iterative_divider #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Launch one operation from a negedge; returns edges to done (-1 on timeout)
  // and the number of sampled cycles with busy high. Ends on the done cycle's negedge.
  task automatic run_op(input logic sgn, input logic [N-1:0] dd, input logic [N-1:0] dv,
                        output int cyc, output int bcnt);
    is_signed = sgn; dividend = dd; divisor = dv; start = 1'b1;
    cyc = -1; bcnt = 0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (busy) bcnt++;
    for (int k = 1; k < 100; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %0b want 0", done); end
    n_cmp++; if (quotient !== 32'd0) begin n_bad++; $display("FAIL reset_q got %h want 0", quotient); end
    n_cmp++; if (remainder !== 32'd0) begin n_bad++; $display("FAIL reset_r got %h want 0", remainder); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL reset_dbz got %0b want 0", div_by_zero); end
  endtask

  task automatic test_unsigned_basic();
    int cyc, bcnt;
    run_op(1'b0, 32'd100, 32'd7, cyc, bcnt);
    n_cmp++; if (cyc !== 33) begin n_bad++; $display("FAIL ubasic_latency got %0d want 33", cyc); end
    n_cmp++; if (bcnt !== 33) begin n_bad++; $display("FAIL ubasic_busy_cycles got %0d want 33", bcnt); end
    n_cmp++; if (quotient !== 32'd14) begin n_bad++; $display("FAIL ubasic_q got %0d want 14", quotient); end
    n_cmp++; if (remainder !== 32'd2) begin n_bad++; $display("FAIL ubasic_r got %0d want 2", remainder); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL ubasic_dbz got %0b want 0", div_by_zero); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL ubasic_done_pulse got %0b want 0", done); end
    n_cmp++; if (quotient !== 32'd14) begin n_bad++; $display("FAIL ubasic_q_hold got %0d want 14", quotient); end
  endtask

  task automatic test_signed_matrix();
    logic [N-1:0] dd_t [4] = '{32'hFFFFFF9C, 32'd100, 32'hFFFFFF9C, 32'h80000000};
    logic [N-1:0] dv_t [4] = '{32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFFF};
    logic [N-1:0] q_t  [4] = '{32'hFFFFFFF2, 32'hFFFFFFF2, 32'd14, 32'h80000000};
    logic [N-1:0] r_t  [4] = '{32'hFFFFFFFE, 32'd2, 32'hFFFFFFFE, 32'd0};
    int cyc, bcnt;
    for (int i = 0; i < 4; i++) begin
      run_op(1'b1, dd_t[i], dv_t[i], cyc, bcnt);
      n_cmp++; if (cyc !== 33) begin n_bad++; $display("FAIL signed%0d_latency got %0d want 33", i, cyc); end
      n_cmp++; if (quotient !== q_t[i]) begin n_bad++; $display("FAIL signed%0d_q got %h want %h", i, quotient, q_t[i]); end
      n_cmp++; if (remainder !== r_t[i]) begin n_bad++; $display("FAIL signed%0d_r got %h want %h", i, remainder, r_t[i]); end
      n_cmp++; if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL signed%0d_dbz got %0b want 0", i, div_by_zero); end
    end
  endtask

  task automatic test_div_by_zero();
    int cyc, bcnt;
    run_op(1'b0, 32'hDEADBEEF, 32'd0, cyc, bcnt);
    n_cmp++; if (cyc !== 1) begin n_bad++; $display("FAIL div0_latency got %0d want 1", cyc); end
    n_cmp++; if (quotient !== 32'd0) begin n_bad++; $display("FAIL div0_q got %h want 0", quotient); end
    n_cmp++; if (remainder !== 32'hDEADBEEF) begin n_bad++; $display("FAIL div0_r got %h want deadbeef", remainder); end
    n_cmp++; if (div_by_zero !== 1'b1) begin n_bad++; $display("FAIL div0_flag got %0b want 1", div_by_zero); end
    @(negedge clk);
    run_op(1'b0, 32'd9, 32'd3, cyc, bcnt);
    n_cmp++; if (cyc !== 33) begin n_bad++; $display("FAIL after_div0_latency got %0d want 33", cyc); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL after_div0_flag got %0b want 0", div_by_zero); end
    n_cmp++; if (quotient !== 32'd3) begin n_bad++; $display("FAIL after_div0_q got %0d want 3", quotient); end
    n_cmp++; if (remainder !== 32'd0) begin n_bad++; $display("FAIL after_div0_r got %0d want 0", remainder); end
  endtask

  task automatic test_extremes();
    logic [N-1:0] dd_t [3] = '{32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF};
    logic [N-1:0] dv_t [3] = '{32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [N-1:0] q_t  [3] = '{32'hFFFFFFFF, 32'd0, 32'd1};
    logic [N-1:0] r_t  [3] = '{32'd0, 32'd5, 32'd0};
    int cyc, bcnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      run_op(1'b0, dd_t[i], dv_t[i], cyc, bcnt);
      n_cmp++; if (quotient !== q_t[i]) begin n_bad++; $display("FAIL extreme%0d_q got %h want %h", i, quotient, q_t[i]); end
      n_cmp++; if (remainder !== r_t[i]) begin n_bad++; $display("FAIL extreme%0d_r got %h want %h", i, remainder, r_t[i]); end
    end
  endtask

  task automatic test_ignored_start();
    int cyc;
    @(negedge clk);
    is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = -1;
    for (int k = 1; k < 100; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 10) begin
        dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        cyc = k;
        break;
      end
    end
    start = 1'b0;
    n_cmp++; if (cyc !== 33) begin n_bad++; $display("FAIL ignore_latency got %0d want 33", cyc); end
    n_cmp++; if (quotient !== 32'd14) begin n_bad++; $display("FAIL ignore_q got %0d want 14", quotient); end
    n_cmp++; if (remainder !== 32'd2) begin n_bad++; $display("FAIL ignore_r got %0d want 2", remainder); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ignore_not_queued got busy=%0b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int cyc, bcnt;
    @(negedge clk);
    run_op(1'b0, 32'd77, 32'd10, cyc, bcnt);
    n_cmp++; if (quotient !== 32'd7) begin n_bad++; $display("FAIL b2b_first_q got %0d want 7", quotient); end
    n_cmp++; if (remainder !== 32'd7) begin n_bad++; $display("FAIL b2b_first_r got %0d want 7", remainder); end
    // still in the done cycle: this start must be accepted
    run_op(1'b0, 32'd1000, 32'd3, cyc, bcnt);
    n_cmp++; if (cyc !== 33) begin n_bad++; $display("FAIL b2b_latency got %0d want 33", cyc); end
    n_cmp++; if (quotient !== 32'd333) begin n_bad++; $display("FAIL b2b_second_q got %0d want 333", quotient); end
    n_cmp++; if (remainder !== 32'd1) begin n_bad++; $display("FAIL b2b_second_r got %0d want 1", remainder); end
  endtask

  task automatic test_reset_mid_op();
    int cyc, bcnt, seen;
    @(negedge clk);
    is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (16) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got %0b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL midrst_done got %0b want 0", done); end
    n_cmp++; if (quotient !== 32'd0) begin n_bad++; $display("FAIL midrst_q got %h want 0", quotient); end
    n_cmp++; if (remainder !== 32'd0) begin n_bad++; $display("FAIL midrst_r got %h want 0", remainder); end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL midrst_no_done got %0d pulses want 0", seen); end
    run_op(1'b0, 32'd50, 32'd5, cyc, bcnt);
    n_cmp++; if (cyc !== 33) begin n_bad++; $display("FAIL postrst_latency got %0d want 33", cyc); end
    n_cmp++; if (quotient !== 32'd10) begin n_bad++; $display("FAIL postrst_q got %0d want 10", quotient); end
    n_cmp++; if (remainder !== 32'd0) begin n_bad++; $display("FAIL postrst_r got %0d want 0", remainder); end
  endtask

  initial begin
    test_reset();
    test_unsigned_basic();
    test_signed_matrix();
    test_div_by_zero();
    test_extremes();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
